rptr_empty_fwft: RTL
====================

// Module: rptr_empty_fwft
// PURPOSE
//  Read-side pointer, empty and first-word-fall-through (FWFT) logic for the async FIFO, in the rclk domain.
//  Keeps the binary read address for the memory and a Gray read pointer for the 2-FF sync into wclk.
//  Compares its Gray pointer with the synchronized write pointer to detect empty and report occupancy.
//  Prefetches the head word into an output register with a valid/ready handshake.
// PARAMETERS
//  ASIZE          4   memory address width; depth = 2**ASIZE; pointers are ASIZE+1 bits
//  DSIZE          8   data word width
//  AEMPTY_THRESH  2   raempty asserts when memory occupancy <= this value
// PORTS
//  rclk       in   1        read clock; all state on posedge
//  rrst       in   1        async reset, active-high; all state cleared immediately
//  rq2_wptr   in   ASIZE+1  Gray write pointer, already 2-FF synchronized into rclk
//  raddr      out  ASIZE    binary memory read address = rbin[ASIZE-1:0]
//  rptr       out  ASIZE+1  registered Gray read pointer, to the wclk synchronizer
//  rdata_mem  in   DSIZE    memory read data for raddr (combinational read)
//  rdata      out  DSIZE    registered head-of-FIFO word
//  rvalid     out  1        rdata holds an unconsumed word
//  rready     in   1        consumer accepts rdata this cycle when rvalid=1
//  rempty     out  1        registered memory-empty flag (excludes the output register)
//  raempty    out  1        registered almost-empty flag
//  rlevel     out  ASIZE+1  registered memory occupancy, 0..2**ASIZE
// BEHAVIOUR
//  Reset (rrst=1, async): rbin=0, rptr=0, rdata=0, rvalid=0, rempty=1, raempty=1, rlevel=0.
//  pop  = ~rempty & (~rvalid | rready)        internal memory read strobe
//  rbinnext  = rbin + pop (mod 2**(ASIZE+1))
//  rgraynext = (rbinnext>>1) ^ rbinnext
//  Each edge: rbin<=rbinnext; rptr<=rgraynext; rempty<=(rgraynext==rq2_wptr).
//  Occupancy: wbin_s = Gray-to-binary(rq2_wptr); rlevel<=(wbin_s-rbinnext) mod 2**(ASIZE+1).
//  raempty <= (next rlevel <= AEMPTY_THRESH); same cycle as the rlevel update.
//  Output stage:
//   - pop: rdata<=rdata_mem (word at current raddr); rvalid<=1
//   - no pop and rvalid&rready: rvalid<=0; rdata holds its last value
//   - otherwise rdata and rvalid hold; rdata is stable while rvalid&~rready
//  Throughput: one word per rclk with rready held high and the memory non-empty.
//  Latency: change on rq2_wptr -> rempty falls at the 1st edge -> rvalid rises at the 2nd edge.
//  rready with rvalid=0 is ignored.
//  Simultaneous consume and pop: rvalid stays 1; rdata takes the new word.
//  Empty is pessimistic: a write becomes visible only after sync delay.
//   - The read side never pops an unwritten location.
//   - Popping the last word makes rempty rise at that same edge (rgraynext==rq2_wptr).
//  Wrap: rbin and rptr roll from 2**(ASIZE+1)-1 to 0.
//   - Only the Gray MSB pair distinguishes a lap.
//   - rlevel modular subtraction stays correct across the wrap.
//  Reset mid-operation discards any held word (rvalid->0).
//   - rrst must be asserted together with the write-side reset.
// TESTING
//  T1 reset: rrst=1 with rvalid=1 mid-stream -> same cycle rvalid=0, rptr=0, rempty=1, raempty=1, rlevel=0.
//  T2 single word: rq2_wptr 00000->00001, rready=0
//   -> edge1: rempty=0, rlevel=1
//   -> edge2: rvalid=1, rdata=mem[0], raddr=1, rempty=1, rlevel=0.
//  T3 backpressure: rq2_wptr=bin 3, rready=0
//   -> exactly one pop; rvalid=1; rdata=mem[0] stable 10 cycles; rlevel=2; raempty=1.
//   -> then rready=1 gives mem[1], mem[2] on consecutive edges.
//  T4 streaming: 16 words preloaded, rready=1
//   -> 16 words on 16 consecutive cycles, in order, no gaps.
//   -> rempty=1 after the last pop; rvalid falls 1 cycle after the last word is consumed.
//  T5 wrap: 40 words through, random rready
//   -> rptr Gray after 31 pops = 10000; after 32 pops = 00000.
//   -> data order intact, no word dropped or duplicated.
//  T6 almost-empty (AEMPTY_THRESH=2): level 4 draining
//   -> raempty=0 at rlevel 4 and 3; raempty=1 in the same cycle rlevel becomes 2.

Source files
------------

// File: rtl/rptr_empty_fwft.sv
// Read-side pointer, empty/almost-empty and occupancy logic for an async FIFO,
// with a first-word-fall-through output register on a valid/ready handshake.
module rptr_empty_fwft #(
    parameter int ASIZE         = 4,
    parameter int DSIZE         = 8,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic [ASIZE:0]   rq2_wptr,
    output logic [ASIZE-1:0] raddr,
    output logic [ASIZE:0]   rptr,
    input  logic [DSIZE-1:0] rdata_mem,
    output logic [DSIZE-1:0] rdata,
    output logic             rvalid,
    input  logic             rready,
    output logic             rempty,
    output logic             raempty,
    output logic [ASIZE:0]   rlevel
);

    localparam logic [ASIZE:0] ATH = (ASIZE + 1)'(AEMPTY_THRESH);

    logic [ASIZE:0] rbin;
    logic [ASIZE:0] rbinnext;
    logic [ASIZE:0] rgraynext;
    logic [ASIZE:0] wbin_s;
    logic [ASIZE:0] levelnext;
    logic           pop;

    // The output register refills whenever it is empty or being drained.
    always_comb begin
        pop       = ~rempty & (~rvalid | rready);
        rbinnext  = rbin + {{ASIZE{1'b0}}, pop};
        rgraynext = (rbinnext >> 1) ^ rbinnext;
        wbin_s    = '0;
        for (int i = 0; i <= ASIZE; i++) begin
            wbin_s[i] = ^(rq2_wptr >> i);
        end
        levelnext = wbin_s - rbinnext;
    end

    assign raddr = rbin[ASIZE-1:0];

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            rbin    <= '0;
            rptr    <= '0;
            rempty  <= 1'b1;
            raempty <= 1'b1;
            rlevel  <= '0;
        end else begin
            rbin    <= rbinnext;
            rptr    <= rgraynext;
            rempty  <= (rgraynext == rq2_wptr);
            raempty <= (levelnext <= ATH);
            rlevel  <= levelnext;
        end
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else if (pop) begin
            rdata  <= rdata_mem;
            rvalid <= 1'b1;
        end else if (rvalid && rready) begin
            rvalid <= 1'b0;
        end
    end

endmodule
